// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] curr_pc;
        logic [XLEN-1:0] next_pc;
    } decode_signals;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        STALL = 2'd1,
        DROP  = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu_skid_buf.sv
// One-entry skid buffer holding a fetched word and its PC while the decoder stalls.
import ifu_pkg::*;

module ifu_skid_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [31:0]     push_instr,
    input  logic [XLEN-1:0] push_pc,
    output logic            full,
    output logic [31:0]     head_instr,
    output logic [XLEN-1:0] head_pc
);

    logic            full_r;
    logic [31:0]     instr_r;
    logic [XLEN-1:0] pc_r;

    // occupancy flag; flush wins over a same-cycle push
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            full_r <= 1'b0;
        end else if (push) begin
            full_r <= 1'b1;
        end else if (pop) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

    // payload storage, only written on push
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_r <= NOP_INSTR;
            pc_r    <= {XLEN{1'b0}};
        end else if (push) begin
            instr_r <= push_instr;
            pc_r    <= push_pc;
        end else begin
            instr_r <= instr_r;
            pc_r    <= pc_r;
        end
    end

    assign full       = full_r;
    assign head_instr = instr_r;
    assign head_pc    = pc_r;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC, single-outstanding fetch FSM, OUT slot plus skid buffer.
// Optional IFU_PERF_CNT_EN adds delivered-instruction and decoder-stall counters.
import ifu_pkg::*;

module ifu #(
    parameter int              XLEN     = ifu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            id_valid,
    input  logic            id_ready,
`ifdef IFU_PERF_CNT_EN
    output logic [XLEN-1:0] perf_fetch_cnt,
    output logic [XLEN-1:0] perf_stall_cnt,
`endif
    output decode_signals   signals_out
);

    localparam logic [XLEN-1:0] PC_INC   = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] PC_ALIGN = {{(XLEN-2){1'b1}}, 2'b00};

    ifu_state_e      state_r, state_nxt_s;
    logic [XLEN-1:0] pc_r, pc_nxt_s;
    logic [XLEN-1:0] drop_addr_r, drop_addr_nxt_s;
    logic            out_valid_r, out_valid_nxt_s;
    decode_signals   out_r, out_nxt_s;
    logic            req_block_r;
    logic            imem_req_s, ack_s, consume_s;
    logic            skid_push_s, skid_pop_s, skid_flush_s, skid_full_s;
    logic [31:0]     skid_instr_s;
    logic [XLEN-1:0] skid_pc_s;

    ifu_skid_buf #(.XLEN(XLEN)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (skid_push_s),
        .pop        (skid_pop_s),
        .flush      (skid_flush_s),
        .push_instr (imem_rdata),
        .push_pc    (pc_r),
        .full       (skid_full_s),
        .head_instr (skid_instr_s),
        .head_pc    (skid_pc_s)
    );

    // req_block_r keeps the bus quiet for the first cycle after reset
    assign imem_req_s = (state_r != STALL) && !req_block_r;
    assign ack_s      = imem_ack && imem_req_s;
    assign consume_s  = out_valid_r && id_ready;

    // next-state, PC and OUT/SKID steering
    always_comb begin
        state_nxt_s     = state_r;
        pc_nxt_s        = pc_r;
        drop_addr_nxt_s = drop_addr_r;
        out_valid_nxt_s = out_valid_r;
        out_nxt_s       = out_r;
        skid_push_s     = 1'b0;
        skid_pop_s      = 1'b0;
        skid_flush_s    = 1'b0;
        if (redirect_valid) begin
            out_valid_nxt_s = 1'b0;
            skid_flush_s    = 1'b1;
            pc_nxt_s        = redirect_pc & PC_ALIGN;
            case (state_r)
                REQ: begin
                    if (ack_s) begin
                        state_nxt_s = REQ;
                    end else begin
                        state_nxt_s     = DROP;
                        drop_addr_nxt_s = pc_r;
                    end
                end
                STALL: state_nxt_s = REQ;
                // a stale request that completes this cycle needs no further drop
                DROP: begin
                    if (ack_s) begin
                        state_nxt_s = REQ;
                    end else begin
                        state_nxt_s = DROP;
                    end
                end
                default: state_nxt_s = REQ;
            endcase
        end else begin
            if (consume_s) begin
                out_valid_nxt_s = 1'b0;
            end else begin
                out_valid_nxt_s = out_valid_r;
            end
            case (state_r)
                REQ: begin
                    if (ack_s) begin
                        pc_nxt_s = pc_r + PC_INC;
                        if (!out_valid_r || consume_s) begin
                            out_valid_nxt_s = 1'b1;
                            out_nxt_s = '{instr: imem_rdata, curr_pc: pc_r,
                                          next_pc: pc_r + PC_INC};
                        end else begin
                            skid_push_s = 1'b1;
                            state_nxt_s = STALL;
                        end
                    end else begin
                        state_nxt_s = REQ;
                    end
                end
                STALL: begin
                    if (consume_s && skid_full_s) begin
                        skid_pop_s      = 1'b1;
                        out_valid_nxt_s = 1'b1;
                        out_nxt_s = '{instr: skid_instr_s, curr_pc: skid_pc_s,
                                      next_pc: skid_pc_s + PC_INC};
                        state_nxt_s = REQ;
                    end else if (!skid_full_s) begin
                        state_nxt_s = REQ;
                    end else begin
                        state_nxt_s = STALL;
                    end
                end
                DROP: begin
                    if (ack_s) begin
                        state_nxt_s = REQ;
                    end else begin
                        state_nxt_s = DROP;
                    end
                end
                default: state_nxt_s = REQ;
            endcase
        end
    end

    // state, PC and OUT registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= REQ;
            pc_r        <= RESET_PC;
            drop_addr_r <= RESET_PC;
            out_valid_r <= 1'b0;
            out_r       <= '{instr: NOP_INSTR, curr_pc: RESET_PC,
                             next_pc: RESET_PC + PC_INC};
            req_block_r <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            drop_addr_r <= drop_addr_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_r       <= out_nxt_s;
            req_block_r <= 1'b0;
        end
    end

    assign imem_req    = imem_req_s;
    assign imem_addr   = (state_r == DROP) ? drop_addr_r : pc_r;
    assign id_valid    = out_valid_r;
    assign signals_out = out_r;

`ifdef IFU_PERF_CNT_EN
    logic [XLEN-1:0] fetch_cnt_r, stall_cnt_r;

    // delivery and decoder-stall counters, wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_r <= {XLEN{1'b0}};
            stall_cnt_r <= {XLEN{1'b0}};
        end else begin
            fetch_cnt_r <= fetch_cnt_r + XLEN'(out_valid_r && id_ready);
            stall_cnt_r <= stall_cnt_r + XLEN'(out_valid_r && !id_ready);
        end
    end

    assign perf_fetch_cnt = fetch_cnt_r;
    assign perf_stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: streaming, decoder stall, redirects, reset, PC wrap, counters.
import ifu_pkg::*;

module tb_ifu;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            redirect_valid = 1'b0;
    logic [31:0]     redirect_pc = 32'h0;
    logic            imem_req;
    logic [31:0]     imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            id_valid;
    logic            id_ready = 1'b1;
    decode_signals   signals_out;
    logic            auto_ack = 1'b1;
    logic            man_ack = 1'b0;
`ifdef IFU_PERF_CNT_EN
    logic [31:0]     perf_fetch_cnt;
    logic [31:0]     perf_stall_cnt;
`endif

    int check_cnt = 0;
    int pass_cnt  = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign imem_ack   = auto_ack ? imem_req : man_ack;
    assign imem_rdata = word_of(imem_addr);

    ifu dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
`ifdef IFU_PERF_CNT_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .signals_out    (signals_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc);
        check_eq({tag, "_valid"}, 64'(id_valid), 64'd1);
        check_eq({tag, "_pc"}, 64'(signals_out.curr_pc), 64'(pc));
        check_eq({tag, "_next"}, 64'(signals_out.next_pc), 64'(pc + 32'd4));
        check_eq({tag, "_instr"}, 64'(signals_out.instr), 64'(word_of(pc)));
    endtask

    initial begin
        // 1: reset state, then streaming at one instruction per cycle
        step();
        step();
        check_eq("rst_valid", 64'(id_valid), 64'd0);
        check_eq("rst_req", 64'(imem_req), 64'd0);
        check_eq("rst_instr", 64'(signals_out.instr), 64'h13);
        check_eq("rst_pc", 64'(signals_out.curr_pc), 64'h0);
        check_eq("rst_next", 64'(signals_out.next_pc), 64'h4);
        rst = 1'b0;
        check_eq("post_rst_req", 64'(imem_req), 64'd0);
        step();
        check_eq("first_req", 64'(imem_req), 64'd1);
        check_eq("first_addr", 64'(imem_addr), 64'h0);
        check_eq("first_valid_lat", 64'(id_valid), 64'd0);
        step();
        check_out("s0", 32'h0);
        step();
        check_out("s4", 32'h4);
        step();
        check_out("s8", 32'h8);

        // 2: decoder stalls on pc 8, word 12 parks in the skid buffer
        id_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check_out("hold8", 32'h8);
            check_eq("stall_req", 64'(imem_req), 64'd0);
        end
        id_ready = 1'b1;
        step();
        check_out("drain12", 32'hC);
        check_eq("resume_addr", 64'(imem_addr), 64'h10);
        step();
        check_out("drain16", 32'h10);

        // 3: slow bus, redirect while waiting, stale word dropped
        auto_ack = 1'b0;
        man_ack  = 1'b0;
        step();
        check_eq("wait_valid", 64'(id_valid), 64'd0);
        check_eq("wait_addr", 64'(imem_addr), 64'h14);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        check_eq("drop_req", 64'(imem_req), 64'd1);
        check_eq("drop_addr", 64'(imem_addr), 64'h14);
        step();
        check_eq("drop_addr_hold", 64'(imem_addr), 64'h14);
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        check_eq("drop_discard", 64'(id_valid), 64'd0);
        check_eq("tgt_addr", 64'(imem_addr), 64'h100);
        auto_ack = 1'b1;
        step();
        check_out("tgt100", 32'h100);

        // 4: redirect to unaligned 'h203 together with ack and a live OUT
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        id_ready       = 1'b0;
        step();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        check_eq("redir_valid", 64'(id_valid), 64'd0);
        check_eq("redir_addr", 64'(imem_addr), 64'h200);
        step();
        check_out("tgt200", 32'h200);

        // 5: reset during STALL with the skid buffer full
        id_ready = 1'b0;
        step();
        check_eq("stall_before_rst", 64'(imem_req), 64'd0);
        rst = 1'b1;
        step();
        rst      = 1'b0;
        id_ready = 1'b1;
        check_eq("rst2_valid", 64'(id_valid), 64'd0);
        check_eq("rst2_req", 64'(imem_req), 64'd0);
        check_eq("rst2_instr", 64'(signals_out.instr), 64'h13);
        step();
        check_eq("rst2_addr", 64'(imem_addr), 64'h0);
        check_eq("rst2_req_on", 64'(imem_req), 64'd1);
        step();
        check_out("rst2_s0", 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        check_eq("wrap_pc", 64'(signals_out.curr_pc), 64'hFFFF_FFFC);
        check_eq("wrap_next", 64'(signals_out.next_pc), 64'h0);
        step();
        check_out("wrap_s0", 32'h0);

`ifdef IFU_PERF_CNT_EN
        // 6: 10 deliveries and 4 stall cycles from a fresh reset
        rst = 1'b1;
        step();
        check_eq("perf_rst", 64'(perf_fetch_cnt), 64'd0);
        rst = 1'b0;
        step();
        step();
        for (int i = 0; i < 6; i++) step();
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check_eq("perf_fetch", 64'(perf_fetch_cnt), 64'd10);
        check_eq("perf_stall", 64'(perf_stall_cnt), 64'd4);
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
